// File: rtl/ddr3_app_arbiter.sv
// Two-port arbiter in front of a DDR3 user interface: round-robin grant with a
// hold limit, command/data muxing, and a tag FIFO that routes read returns.
module ddr3_app_arbiter #(
  parameter int TAG_DEPTH = 32,
  parameter int MAX_HOLD  = 64
) (
  input  logic         ui_clk,
  input  logic         rst_n,
  input  logic         init_calib_complete,

  input  logic         p0_req,
  input  logic         p0_app_en,
  input  logic         p0_app_wdf_wren,
  input  logic         p0_app_wdf_end,
  input  logic [2:0]   p0_app_cmd,
  input  logic [27:0]  p0_app_addr,
  input  logic [127:0] p0_app_wdf_data,
  output logic         p0_app_rdy,
  output logic         p0_app_wdf_rdy,
  output logic         p0_app_rd_data_valid,
  output logic [127:0] p0_app_rd_data,

  input  logic         p1_req,
  input  logic         p1_app_en,
  input  logic         p1_app_wdf_wren,
  input  logic         p1_app_wdf_end,
  input  logic [2:0]   p1_app_cmd,
  input  logic [27:0]  p1_app_addr,
  input  logic [127:0] p1_app_wdf_data,
  output logic         p1_app_rdy,
  output logic         p1_app_wdf_rdy,
  output logic         p1_app_rd_data_valid,
  output logic [127:0] p1_app_rd_data,

  input  logic         app_rdy,
  input  logic         app_wdf_rdy,
  input  logic         app_rd_data_valid,
  input  logic [127:0] app_rd_data,
  output logic         app_en,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  output logic [2:0]   app_cmd,
  output logic [27:0]  app_addr,
  output logic [127:0] app_wdf_data,

  output logic         tag_err,
  output logic [1:0]   dbg_state
);

  // Handshake: a command transfers on any cycle where app_en and app_rdy are
  // both 1; a write beat transfers when app_wdf_wren and app_wdf_rdy are both 1.
  // Read data has no back-pressure: app_rd_data_valid is a one-cycle strobe.

  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] TAG_FULL_CNT = CW'(TAG_DEPTH);
  localparam logic [HW-1:0] HOLD_MAX     = HW'(MAX_HOLD);
  localparam logic [2:0]    CMD_READ     = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_last_gnt;
  logic            w_release;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_tag_mem [TAG_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_tag_cnt;
  logic            r_tag_err;

  logic            w_tag_full;
  logic            w_tag_empty;
  logic            w_p0_rd_blk;
  logic            w_p1_rd_blk;
  logic            w_gnt_id;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_underflow;
  logic            w_head;

  assign w_tag_full  = (r_tag_cnt == TAG_FULL_CNT);
  assign w_tag_empty = (r_tag_cnt == '0);
  assign w_p0_rd_blk = (p0_app_cmd == CMD_READ) && w_tag_full;
  assign w_p1_rd_blk = (p1_app_cmd == CMD_READ) && w_tag_full;
  assign w_gnt_id    = (r_state == ST_GNT1);

  assign p0_app_rdy     = app_rdy && (r_state == ST_GNT0) && !w_p0_rd_blk;
  assign p1_app_rdy     = app_rdy && (r_state == ST_GNT1) && !w_p1_rd_blk;
  assign p0_app_wdf_rdy = app_wdf_rdy && (r_state == ST_GNT0);
  assign p1_app_wdf_rdy = app_wdf_rdy && (r_state == ST_GNT1);

  // A read held off by a full tag FIFO never reaches the DDR, so every command
  // the IP accepts is also one the port sees accepted.
  always_comb begin
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    app_cmd      = 3'd0;
    app_addr     = 28'd0;
    app_wdf_data = 128'd0;
    case (r_state)
      ST_GNT0: begin
        app_en       = p0_app_en && !w_p0_rd_blk;
        app_wdf_wren = p0_app_wdf_wren;
        app_wdf_end  = p0_app_wdf_end;
        app_cmd      = p0_app_cmd;
        app_addr     = p0_app_addr;
        app_wdf_data = p0_app_wdf_data;
      end
      ST_GNT1: begin
        app_en       = p1_app_en && !w_p1_rd_blk;
        app_wdf_wren = p1_app_wdf_wren;
        app_wdf_end  = p1_app_wdf_end;
        app_cmd      = p1_app_cmd;
        app_addr     = p1_app_addr;
        app_wdf_data = p1_app_wdf_data;
      end
      default: ;
    endcase
  end

  assign w_accept    = app_en && app_rdy;
  assign w_pop       = app_rd_data_valid && !w_tag_empty;
  assign w_push      = w_accept && (app_cmd == CMD_READ) && (!w_tag_full || w_pop);
  assign w_underflow = app_rd_data_valid && w_tag_empty;
  assign w_head      = r_tag_mem[r_rd_ptr];

  assign p0_app_rd_data_valid = w_pop && !w_head;
  assign p1_app_rd_data_valid = w_pop && w_head;
  assign p0_app_rd_data       = app_rd_data;
  assign p1_app_rd_data       = app_rd_data;
  assign tag_err              = r_tag_err;
  assign dbg_state            = r_state;

  always_comb begin
    w_next_state = r_state;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (init_calib_complete) begin
          if (p0_req && p1_req) w_next_state = r_last_gnt ? ST_GNT0 : ST_GNT1;
          else if (p0_req)      w_next_state = ST_GNT0;
          else if (p1_req)      w_next_state = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!p0_req) begin
          w_next_state = ST_IDLE;
          w_release    = 1'b1;
        end else if ((r_hold_cnt >= HOLD_MAX) && p1_req) begin
          w_next_state = ST_GNT1;
        end
      end
      ST_GNT1: begin
        if (!p1_req) begin
          w_next_state = ST_IDLE;
          w_release    = 1'b1;
        end else if ((r_hold_cnt >= HOLD_MAX) && p0_req) begin
          w_next_state = ST_GNT0;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_release) r_last_gnt <= w_gnt_id;
    end
  end

  // Hold counter saturates so a port left alone keeps its grant indefinitely.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_hold_cnt <= '0;
    end else if (w_accept && (r_hold_cnt != HOLD_MAX)) begin
      r_hold_cnt <= r_hold_cnt + HW'(1);
    end
  end

  always_ff @(posedge ui_clk) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= w_gnt_id;
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_tag_cnt <= '0;
      r_tag_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_tag_cnt <= r_tag_cnt + CW'(1);
        2'b01:   r_tag_cnt <= r_tag_cnt - CW'(1);
        default: ;
      endcase
      if (w_underflow) r_tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Directed bench for ddr3_app_arbiter: calibration gating, round-robin tie,
// hold-limit handover, read-tag routing, tag-full blocking and underflow.
module tb_ddr3_app_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_G0   = 2'd1;
  localparam logic [1:0] S_G1   = 2'd2;

  logic         ui_clk;
  logic         rst_n;
  logic         init_calib_complete;
  logic         p0_req, p0_app_en, p0_app_wdf_wren, p0_app_wdf_end;
  logic [2:0]   p0_app_cmd;
  logic [27:0]  p0_app_addr;
  logic [127:0] p0_app_wdf_data;
  logic         p0_app_rdy, p0_app_wdf_rdy, p0_app_rd_data_valid;
  logic [127:0] p0_app_rd_data;
  logic         p1_req, p1_app_en, p1_app_wdf_wren, p1_app_wdf_end;
  logic [2:0]   p1_app_cmd;
  logic [27:0]  p1_app_addr;
  logic [127:0] p1_app_wdf_data;
  logic         p1_app_rdy, p1_app_wdf_rdy, p1_app_rd_data_valid;
  logic [127:0] p1_app_rd_data;
  logic         app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [127:0] app_rd_data;
  logic         app_en, app_wdf_wren, app_wdf_end;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic [127:0] app_wdf_data;
  logic         tag_err;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  ddr3_app_arbiter #(.TAG_DEPTH(4), .MAX_HOLD(4)) dut (
    .ui_clk(ui_clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .p0_req(p0_req), .p0_app_en(p0_app_en), .p0_app_wdf_wren(p0_app_wdf_wren),
    .p0_app_wdf_end(p0_app_wdf_end), .p0_app_cmd(p0_app_cmd), .p0_app_addr(p0_app_addr),
    .p0_app_wdf_data(p0_app_wdf_data), .p0_app_rdy(p0_app_rdy), .p0_app_wdf_rdy(p0_app_wdf_rdy),
    .p0_app_rd_data_valid(p0_app_rd_data_valid), .p0_app_rd_data(p0_app_rd_data),
    .p1_req(p1_req), .p1_app_en(p1_app_en), .p1_app_wdf_wren(p1_app_wdf_wren),
    .p1_app_wdf_end(p1_app_wdf_end), .p1_app_cmd(p1_app_cmd), .p1_app_addr(p1_app_addr),
    .p1_app_wdf_data(p1_app_wdf_data), .p1_app_rdy(p1_app_rdy), .p1_app_wdf_rdy(p1_app_wdf_rdy),
    .p1_app_rd_data_valid(p1_app_rd_data_valid), .p1_app_rd_data(p1_app_rd_data),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data(app_rd_data), .app_en(app_en), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_data(app_wdf_data), .tag_err(tag_err), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial begin
    ui_clk = 1'b0;
    forever #5 ui_clk = ~ui_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic drive_idle();
    init_calib_complete = 1'b0;
    p0_req = 1'b0; p0_app_en = 1'b0; p0_app_wdf_wren = 1'b0; p0_app_wdf_end = 1'b0;
    p0_app_cmd = 3'd0; p0_app_addr = 28'd0; p0_app_wdf_data = 128'd0;
    p1_req = 1'b0; p1_app_en = 1'b0; p1_app_wdf_wren = 1'b0; p1_app_wdf_end = 1'b0;
    p1_app_cmd = 3'd0; p1_app_addr = 28'd0; p1_app_wdf_data = 128'd0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0; app_rd_data = 128'd0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_idle();
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    init_calib_complete = 1'b1;
    p0_req = 1'b1; p1_req = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    p0_app_en = 1'b1; app_rd_data_valid = 1'b1;
    step();
    step();
    @(negedge ui_clk);
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, S_IDLE); end
    checks++;
    if ({p0_app_rdy, p1_app_rdy, p0_app_wdf_rdy, p1_app_wdf_rdy} !== 4'b0000) begin
      errors++; $display("FAIL rst_rdy: got %b expected 0000", {p0_app_rdy, p1_app_rdy, p0_app_wdf_rdy, p1_app_wdf_rdy});
    end
    checks++;
    if ({app_en, app_wdf_wren, app_wdf_end, p0_app_rd_data_valid, p1_app_rd_data_valid, tag_err} !== 6'b0) begin
      errors++; $display("FAIL rst_outs: got %b expected 000000",
        {app_en, app_wdf_wren, app_wdf_end, p0_app_rd_data_valid, p1_app_rd_data_valid, tag_err});
    end
    drive_idle();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_calib();
    apply_reset();
    p0_req = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    repeat (3) step();
    @(negedge ui_clk);
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL calib_idle: got %0d expected %0d", dbg_state, S_IDLE); end
    checks++;
    if (p0_app_rdy !== 1'b0) begin errors++; $display("FAIL calib_rdy0: got %b expected 0", p0_app_rdy); end
    init_calib_complete = 1'b1;
    step();
    @(negedge ui_clk);
    checks++;
    if (dbg_state !== S_G0) begin errors++; $display("FAIL calib_gnt0: got %0d expected %0d", dbg_state, S_G0); end
    checks++;
    if ({p0_app_rdy, p0_app_wdf_rdy} !== 2'b11) begin errors++; $display("FAIL calib_rdy1: got %b expected 11", {p0_app_rdy, p0_app_wdf_rdy}); end
    app_rdy = 1'b0;
    #1;
    checks++;
    if (p0_app_rdy !== 1'b0) begin errors++; $display("FAIL calib_follow: got %b expected 0", p0_app_rdy); end
    p0_req = 1'b0;
    step();
    @(negedge ui_clk);
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL calib_release: got %0d expected %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_tie();
    apply_reset();
    init_calib_complete = 1'b1;
    app_rdy = 1'b1;
    p0_req = 1'b1; p1_req = 1'b1;
    p0_app_addr = 28'h1234567; p0_app_wdf_data = 128'hAAAA_0000;
    p1_app_addr = 28'h7654321; p1_app_wdf_data = 128'hBBBB_1111;
    p0_app_en = 1'b1; p0_app_wdf_wren = 1'b1;
    step();
    @(negedge ui_clk);
    checks++;
    if (dbg_state !== S_G0) begin errors++; $display("FAIL tie_first: got %0d expected %0d", dbg_state, S_G0); end
    checks++;
    if ({p0_app_rdy, p1_app_rdy} !== 2'b10) begin errors++; $display("FAIL tie_rdy: got %b expected 10", {p0_app_rdy, p1_app_rdy}); end
    checks++;
    if ({app_en, app_wdf_wren, app_addr, app_wdf_data} !== {1'b1, 1'b1, 28'h1234567, 128'hAAAA_0000}) begin
      errors++; $display("FAIL tie_mux0: got addr %h data %h en %b expected addr 1234567 data aaaa0000 en 1", app_addr, app_wdf_data, app_en);
    end
    p0_app_en = 1'b0; p0_app_wdf_wren = 1'b0;
    p0_req = 1'b0;
    step();
    @(negedge ui_clk);
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL tie_idle: got %0d expected %0d", dbg_state, S_IDLE); end
    checks++;
    if ({app_en, app_addr, app_wdf_data} !== 157'd0) begin errors++; $display("FAIL tie_idle_mux: got addr %h expected 0", app_addr); end
    step();
    @(negedge ui_clk);
    checks++;
    if (dbg_state !== S_G1) begin errors++; $display("FAIL tie_second: got %0d expected %0d", dbg_state, S_G1); end
    checks++;
    if ({app_addr, app_wdf_data} !== {28'h7654321, 128'hBBBB_1111}) begin
      errors++; $display("FAIL tie_mux1: got addr %h data %h expected addr 7654321 data bbbb1111", app_addr, app_wdf_data);
    end
    p1_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic [5:0] pat;
    int accepts;
    logic seen_idle, seen_g1;
    pat = 6'b101101;
    accepts = 0;
    apply_reset();
    init_calib_complete = 1'b1;
    app_wdf_rdy = 1'b1;
    p0_req = 1'b1;
    step();
    p1_req = 1'b1;
    p0_app_en = 1'b1; p0_app_wdf_wren = 1'b1; p0_app_wdf_end = 1'b1; p0_app_cmd = 3'd0;
    for (int i = 0; i < 6; i++) begin
      app_rdy = pat[i];
      @(negedge ui_clk);
      checks++;
      if (dbg_state !== S_G0) begin errors++; $display("FAIL starve_hold[%0d]: got %0d expected %0d", i, dbg_state, S_G0); end
      step();
      if (pat[i]) accepts++;
      if (accepts == 4) break;
    end
    p0_app_en = 1'b0; p0_app_wdf_wren = 1'b0; p0_app_wdf_end = 1'b0;
    app_rdy = 1'b1;
    seen_idle = 1'b0;
    seen_g1 = 1'b0;
    repeat (3) begin
      @(negedge ui_clk);
      if (dbg_state == S_IDLE) seen_idle = 1'b1;
      if (dbg_state == S_G1) seen_g1 = 1'b1;
    end
    checks++;
    if ({seen_idle, seen_g1} !== 2'b01) begin errors++; $display("FAIL starve_switch: got idle=%b gnt1=%b expected idle=0 gnt1=1", seen_idle, seen_g1); end
    checks++;
    if ({p0_app_rdy, p1_app_rdy} !== 2'b01) begin errors++; $display("FAIL starve_rdy: got %b expected 01", {p0_app_rdy, p1_app_rdy}); end
    p0_req = 1'b0; p1_req = 1'b0;
    step();
  endtask

  task automatic test_read_routing();
    logic [0:0] e;
    int n;
    apply_reset();
    init_calib_complete = 1'b1;
    app_rdy = 1'b1;
    p0_req = 1'b1;
    step();
    p0_app_en = 1'b1; p0_app_cmd = 3'd1;
    for (int i = 0; i < 3; i++) begin
      p0_app_addr = 28'(i * 8);
      @(negedge ui_clk);
      checks++;
      if (p0_app_rdy !== 1'b1) begin errors++; $display("FAIL rd0_rdy[%0d]: got %b expected 1", i, p0_app_rdy); end
      step();
      exp_q.push_back(1'b0);
    end
    p0_app_en = 1'b0; p0_req = 1'b0; p1_req = 1'b1;
    step();
    step();
    @(negedge ui_clk);
    checks++;
    if (dbg_state !== S_G1) begin errors++; $display("FAIL rd_gnt1: got %0d expected %0d", dbg_state, S_G1); end
    // p1 read issued in the same cycle as the first return
    p1_app_en = 1'b1; p1_app_cmd = 3'd1;
    app_rd_data_valid = 1'b1; app_rd_data = 128'hA0;
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({p1_app_rd_data_valid, p0_app_rd_data_valid, p1_app_rdy} !== {e, ~e, 1'b1}) begin
      errors++; $display("FAIL rd_pushpop: got v1=%b v0=%b rdy1=%b expected v1=%b v0=%b rdy1=1",
        p1_app_rd_data_valid, p0_app_rd_data_valid, p1_app_rdy, e, ~e);
    end
    checks++;
    if ({p0_app_rd_data, p1_app_rd_data} !== {128'hA0, 128'hA0}) begin
      errors++; $display("FAIL rd_bcast: got %h/%h expected a0/a0", p0_app_rd_data, p1_app_rd_data);
    end
    step();
    exp_q.push_back(1'b1);
    app_rd_data_valid = 1'b0;
    @(negedge ui_clk);
    checks++;
    if (p1_app_rdy !== 1'b1) begin errors++; $display("FAIL rd1_after_pushpop: got %b expected 1", p1_app_rdy); end
    step();
    exp_q.push_back(1'b1);
    p1_app_en = 1'b0;
    n = 1;
    while (exp_q.size() > 0) begin
      repeat ($urandom_range(1, 3)) step();
      n++;
      app_rd_data_valid = 1'b1;
      app_rd_data = 128'(n);
      @(negedge ui_clk);
      e = exp_q.pop_front();
      checks++;
      if ({p1_app_rd_data_valid, p0_app_rd_data_valid} !== {e, ~e}) begin
        errors++; $display("FAIL rd_route[%0d]: got v1=%b v0=%b expected v1=%b v0=%b", n, p1_app_rd_data_valid, p0_app_rd_data_valid, e, ~e);
      end
      step();
      app_rd_data_valid = 1'b0;
    end
    @(negedge ui_clk);
    checks++;
    if (tag_err !== 1'b0) begin errors++; $display("FAIL rd_no_err: got %b expected 0", tag_err); end
    p1_req = 1'b0;
    step();
  endtask

  task automatic test_tag_full();
    logic [0:0] e;
    apply_reset();
    init_calib_complete = 1'b1;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    p0_req = 1'b1;
    step();
    p0_app_en = 1'b1; p0_app_cmd = 3'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ui_clk);
      checks++;
      if (p0_app_rdy !== 1'b1) begin errors++; $display("FAIL full_fill[%0d]: got %b expected 1", i, p0_app_rdy); end
      step();
      exp_q.push_back(1'b0);
    end
    @(negedge ui_clk);
    checks++;
    if (p0_app_rdy !== 1'b0) begin errors++; $display("FAIL full_block: got %b expected 0", p0_app_rdy); end
    p0_app_cmd = 3'd0; p0_app_wdf_wren = 1'b1; p0_app_wdf_end = 1'b1;
    #1;
    checks++;
    if ({p0_app_rdy, p0_app_wdf_rdy, app_en} !== 3'b111) begin
      errors++; $display("FAIL full_write: got %b expected 111", {p0_app_rdy, p0_app_wdf_rdy, app_en});
    end
    step();
    p0_app_en = 1'b0; p0_app_wdf_wren = 1'b0; p0_app_wdf_end = 1'b0;
    app_rd_data_valid = 1'b1;
    @(negedge ui_clk);
    e = exp_q.pop_front();
    checks++;
    if ({p1_app_rd_data_valid, p0_app_rd_data_valid} !== {e, ~e}) begin
      errors++; $display("FAIL full_pop: got v1=%b v0=%b expected v1=%b v0=%b", p1_app_rd_data_valid, p0_app_rd_data_valid, e, ~e);
    end
    step();
    app_rd_data_valid = 1'b0;
    p0_app_en = 1'b1; p0_app_cmd = 3'd1;
    @(negedge ui_clk);
    checks++;
    if (p0_app_rdy !== 1'b1) begin errors++; $display("FAIL full_after_pop: got %b expected 1", p0_app_rdy); end
    step();
    exp_q.push_back(1'b0);
    p0_app_en = 1'b0;
    while (exp_q.size() > 0) begin
      app_rd_data_valid = 1'b1;
      @(negedge ui_clk);
      e = exp_q.pop_front();
      checks++;
      if ({p1_app_rd_data_valid, p0_app_rd_data_valid} !== {e, ~e}) begin
        errors++; $display("FAIL full_drain: got v1=%b v0=%b expected v1=%b v0=%b", p1_app_rd_data_valid, p0_app_rd_data_valid, e, ~e);
      end
      step();
      app_rd_data_valid = 1'b0;
      step();
    end
    @(negedge ui_clk);
    checks++;
    if (tag_err !== 1'b0) begin errors++; $display("FAIL full_no_err: got %b expected 0", tag_err); end
    p0_req = 1'b0;
    step();
  endtask

  task automatic test_underflow();
    apply_reset();
    init_calib_complete = 1'b1;
    app_rdy = 1'b1;
    p0_req = 1'b1;
    step();
    p0_app_en = 1'b1; p0_app_cmd = 3'd1;
    step();
    p0_app_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dbg_state, tag_err} !== {S_IDLE, 1'b0}) begin
      errors++; $display("FAIL uf_rst_midgrant: got state=%0d err=%b expected state=0 err=0", dbg_state, tag_err);
    end
    step();
    p0_req = 1'b0;
    rst_n = 1'b1;
    step();
    app_rd_data_valid = 1'b1;
    @(negedge ui_clk);
    checks++;
    if ({p0_app_rd_data_valid, p1_app_rd_data_valid} !== 2'b00) begin
      errors++; $display("FAIL uf_novalid: got %b expected 00", {p0_app_rd_data_valid, p1_app_rd_data_valid});
    end
    step();
    app_rd_data_valid = 1'b0;
    @(negedge ui_clk);
    checks++;
    if (tag_err !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", tag_err); end
    repeat (5) step();
    @(negedge ui_clk);
    checks++;
    if (tag_err !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b expected 1", tag_err); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tag_err !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b expected 0", tag_err); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Sequence and final report
  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_calib();
    test_tie();
    test_starvation();
    test_read_routing();
    test_tag_full();
    test_underflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_app_arbiter.md
DDR3_APP_ARBITER -- requirements
Module: ddr3_app_arbiter

Interface
REQ-001 Parameter TAG_DEPTH, default 32: read-return tag FIFO depth in entries (power of two).
REQ-002 Parameter MAX_HOLD, default 64: accepted commands after which the grant is released if the other port requests.
REQ-003 ui_clk  in  1  DDR3 user clock; every register is clocked on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 init_calib_complete  in  1  DDR3 calibration done.
REQ-006 pN_req  in  1  port N (N=0,1) wants DDR access; level signal, held while the adapter is in its WRITE or READ state.
REQ-007 pN_app_en, pN_app_wdf_wren, pN_app_wdf_end  in  1 each  port N command/data strobes.
REQ-008 pN_app_cmd  in  3; pN_app_addr  in  28; pN_app_wdf_data  in  128  port N command, address and write data.
REQ-009 pN_app_rdy, pN_app_wdf_rdy  out  1 each  gated ready signals to port N.
REQ-010 pN_app_rd_data_valid  out  1; pN_app_rd_data  out  128  read return to port N.
REQ-011 app_rdy, app_wdf_rdy, app_rd_data_valid  in  1 each; app_rd_data  in  128  from the DDR3 IP.
REQ-012 app_en, app_wdf_wren, app_wdf_end  out  1 each; app_cmd  out  3; app_addr  out  28; app_wdf_data  out  128  to the DDR3 IP.
REQ-013 tag_err  out  1  sticky flag: read data arrived with no outstanding tag.

Function
REQ-014 The arbiter state machine SHALL have three states: IDLE, GNT0, GNT1; the state is registered.
REQ-015 In IDLE, with init_calib_complete=1 and at least one pN_req=1, the FSM SHALL move to GNTn on the next edge; if both ports request, GNT goes to the port opposite last_gnt (round-robin); last_gnt resets to 1, so port 0 wins the first tie.
REQ-016 In IDLE with init_calib_complete=0 the FSM SHALL stay in IDLE.
REQ-017 In GNTn the FSM SHALL return to IDLE one edge after pn_req deasserts; on that edge last_gnt <= n.
REQ-018 In GNTn, hold_cnt SHALL increment per accepted command and reset to 0 on every grant change; when hold_cnt reaches MAX_HOLD and the other port requests, the FSM SHALL go directly to GNT(other).
REQ-019 A command is accepted on any cycle with app_en=1 and app_rdy=1.
REQ-020 pN_app_rdy = app_rdy AND state==GNTn AND NOT(pN_app_cmd==1 AND tag_full); pN_app_wdf_rdy = app_wdf_rdy AND state==GNTn (combinational).
REQ-021 DDR-side outputs SHALL be a combinational mux of the granted port's app_en/app_wdf_wren/app_wdf_end/app_cmd/app_addr/app_wdf_data; in IDLE, app_en=app_wdf_wren=app_wdf_end=0, app_cmd=0, app_addr=0, app_wdf_data=0.
REQ-022 Each accepted command with app_cmd==1 SHALL push the granted port id into the tag FIFO.
REQ-023 Each app_rd_data_valid=1 cycle SHALL pop the tag FIFO and assert pN_app_rd_data_valid for the popped id in the same cycle (0-cycle latency); app_rd_data is broadcast to both pN_app_rd_data.
REQ-024 A simultaneous push and pop SHALL leave the occupancy unchanged; a push is also permitted when the FIFO is full in that cycle only if a pop occurs in the same cycle.
REQ-025 tag_full SHALL equal (occupancy==TAG_DEPTH); read commands are blocked per REQ-020 while it is set.
REQ-026 If app_rd_data_valid=1 while the tag FIFO is empty, both pN_app_rd_data_valid SHALL stay 0 and tag_err SHALL set and hold until reset.
REQ-027 A grant change SHALL NOT flush outstanding tags; read data still routes by tag.

Reset
REQ-028 While rst_n=0: state=IDLE, last_gnt=1, hold_cnt=0, tag FIFO empty, tag_err=0; all outputs 0.
REQ-029 Reset asserted mid-grant or with reads outstanding SHALL discard all tags; read data arriving after release is an underflow per REQ-026.

Verification
REQ-030 Calibration: init_calib_complete=0, p0_req=1 -> state stays IDLE, p0_app_rdy=0; set calib=1 -> GNT0 next edge, p0_app_rdy follows app_rdy.
REQ-031 Tie: both requests rise in the same cycle after reset -> GNT0; p0_req drops -> IDLE -> GNT1.
REQ-032 Starvation: MAX_HOLD=4, p0 streams writes with p1_req=1 -> after 4 accepted commands, GNT1 with no IDLE cycle in between.
REQ-033 Read routing: p0 issues 3 reads, then p1 issues 2 reads; DDR returns 5 valids with gaps -> p0 valid pulses 1-3, p1 valid pulses 4-5.
REQ-034 Tag full: TAG_DEPTH=4, 4 reads outstanding -> p0_app_rdy=0 for reads, writes still accepted; one valid returns -> next read accepted.
REQ-035 Underflow: app_rd_data_valid pulse with no outstanding reads -> no port valid, tag_err=1 held until rst_n=0.
